// File: rtl/ram_dump_streamer.sv
// Streams a contiguous range of memory out over a byte-wide valid/ready upload channel.
// Holds the CPU off the memory arrays (cpu_hold) for as long as a dump is in progress.
module ram_dump_streamer #(
   parameter int ADDR_W = 16,
   parameter int OUT_AW = 25
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] length,
   output logic              busy,
   output logic              done,
   output logic              cpu_hold,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_q,
   output logic              up_valid,
   output logic [7:0]        up_data,
   output logic [OUT_AW-1:0] up_addr,
   input  logic              up_ready
);

   typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, FIN} state_t;

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   state_t            state;
   logic [ADDR_W-1:0] cur;
   logic [ADDR_W-1:0] remaining;
   logic [ADDR_W-1:0] offset;

   assign cpu_hold = busy;

   // NOTE: outputs are registered together with the state, so each one is set on the edge that enters the state it belongs to.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cur       <= '0;
         remaining <= '0;
         offset    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_addr  <= '0;
         mem_rd    <= 1'b0;
         up_valid  <= 1'b0;
         up_data   <= '0;
         up_addr   <= '0;
      end else begin
         done <= 1'b0;
         if (abort && state != IDLE) begin
            // Abort beats a same-cycle handshake; the pending byte is dropped.
            state    <= IDLE;
            busy     <= 1'b0;
            mem_rd   <= 1'b0;
            up_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     cur       <= base_addr;
                     remaining <= length;
                     offset    <= '0;
                     if (length == '0) begin
                        state <= FIN;
                     end else begin
                        state    <= READ;
                        busy     <= 1'b1;
                        mem_rd   <= 1'b1;
                        mem_addr <= base_addr;
                     end
                  end
               end
               READ: begin
                  state  <= WAIT;
                  mem_rd <= 1'b0;
               end
               WAIT: begin
                  state    <= SEND;
                  up_data  <= mem_q;
                  up_addr  <= OUT_AW'(offset);
                  up_valid <= 1'b1;
               end
               SEND: begin
                  if (up_ready) begin
                     up_valid  <= 1'b0;
                     cur       <= cur + ONE;
                     offset    <= offset + ONE;
                     remaining <= remaining - ONE;
                     if (remaining == ONE) begin
                        state <= FIN;
                        busy  <= 1'b0;
                     end else begin
                        state    <= READ;
                        mem_rd   <= 1'b1;
                        mem_addr <= cur + ONE;
                     end
                  end
               end
               FIN: begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ram_dump_streamer.sv
// Self-checking bench for ram_dump_streamer: a memory model, a handshake monitor and
// per-scenario tasks comparing the captured stream against a byte-range reference.
module tb_ram_dump_streamer;

   localparam int         ADDR_W = 16;
   localparam int         OUT_AW = 25;
   localparam logic [7:0] KEY    = 8'h5A;

   typedef struct {
      logic [OUT_AW-1:0] a;
      logic [7:0]        d;
   } beat_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W-1:0] length = '0;
   logic              busy, done, cpu_hold, mem_rd, up_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_q = '0;
   logic [7:0]        up_data;
   logic [OUT_AW-1:0] up_addr;
   logic              up_ready = 1'b1;

   int checks = 0;
   int errors = 0;

   beat_t             hs_q[$];
   logic [ADDR_W-1:0] rd_q[$];
   int                done_cnt = 0;
   int                busy_cnt = 0;
   int                hold_err = 0;

   ram_dump_streamer #(.ADDR_W(ADDR_W), .OUT_AW(OUT_AW)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .base_addr(base_addr), .length(length), .busy(busy), .done(done),
      .cpu_hold(cpu_hold), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_q(mem_q),
      .up_valid(up_valid), .up_data(up_data), .up_addr(up_addr), .up_ready(up_ready)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory: data appears the cycle after the read strobe.
   always @(posedge clk) if (mem_rd) mem_q <= mem_addr[7:0] ^ KEY;

   function automatic logic [7:0] exp_byte(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ KEY;
   endfunction

   beat_t mon_beat;
   always @(negedge clk) begin
      if (!reset) begin
         if (mem_rd) rd_q.push_back(mem_addr);
         if (up_valid && up_ready && !abort) begin
            mon_beat.a = up_addr;
            mon_beat.d = up_data;
            hs_q.push_back(mon_beat);
         end
         if (done) done_cnt++;
         if (busy) busy_cnt++;
         if (cpu_hold !== busy) hold_err++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, want finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l);
      base_addr = b;
      length    = l;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(input bit rnd, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         up_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      up_ready = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      checks++;
      if ({busy, done, cpu_hold, mem_rd, up_valid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b, want 00000", {busy, done, cpu_hold, mem_rd, up_valid});
      end
      checks++;
      if (mem_addr !== '0 || up_data !== '0 || up_addr !== '0) begin
         errors++;
         $display("FAIL reset_data: got mem_addr %h up_data %h up_addr %h, want all 0", mem_addr, up_data, up_addr);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int h0 = hs_q.size();
      int r0 = rd_q.size();
      int d0 = done_cnt;
      bit ok;
      pulse_start(16'hB000, 16'd4);
      @(negedge clk);
      checks++;
      if (!(busy === 1'b1 && mem_rd === 1'b1 && mem_addr === 16'hB000 && up_valid === 1'b0)) begin
         errors++;
         $display("FAIL basic_read_cycle: got busy %b mem_rd %b mem_addr %h up_valid %b, want 1 1 b000 0",
                  busy, mem_rd, mem_addr, up_valid);
      end
      @(negedge clk);
      checks++;
      if (up_valid !== 1'b0 || mem_rd !== 1'b0) begin
         errors++;
         $display("FAIL basic_wait_cycle: got up_valid %b mem_rd %b, want 0 0", up_valid, mem_rd);
      end
      @(negedge clk);
      checks++;
      if (up_valid !== 1'b1 || up_addr !== '0 || up_data !== exp_byte(16'hB000)) begin
         errors++;
         $display("FAIL basic_first_valid: got valid %b addr %h data %h, want 1 0 %h",
                  up_valid, up_addr, up_data, exp_byte(16'hB000));
      end
      @(posedge clk);
      #1;
      wait_done(1'b0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_timeout: got no done, want done"); end
      checks++;
      if (hs_q.size() - h0 != 4) begin
         errors++;
         $display("FAIL basic_count: got %0d bytes, want 4", hs_q.size() - h0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            logic [ADDR_W-1:0] a = 16'hB000 + ADDR_W'(i);
            checks++;
            if (hs_q[h0+i].a !== OUT_AW'(i) || hs_q[h0+i].d !== exp_byte(a)) begin
               errors++;
               $display("FAIL basic_byte%0d: got addr %h data %h, want addr %h data %h",
                        i, hs_q[h0+i].a, hs_q[h0+i].d, i, exp_byte(a));
            end
         end
      end
      checks++;
      if (rd_q.size() - r0 != 4) begin
         errors++;
         $display("FAIL basic_reads: got %0d reads, want 4", rd_q.size() - r0);
      end
      tick();
      checks++;
      if (done_cnt - d0 != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_end: got done pulses %0d busy %b, want 1 0", done_cnt - d0, busy);
      end
   endtask

   task automatic test_stall();
      int h0 = hs_q.size();
      bit ok;
      bit found = 1'b0;
      logic [OUT_AW-1:0] hold_a;
      logic [7:0]        hold_d;
      up_ready = 1'b1;
      pulse_start(16'hB000, 16'd4);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (up_valid && up_addr == OUT_AW'(1)) break;
      end
      @(posedge clk);
      #1;
      up_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (up_valid) begin found = 1'b1; break; end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL stall_valid: got no up_valid, want byte 2 presented"); end
      hold_a = up_addr;
      hold_d = up_data;
      checks++;
      if (hold_a !== OUT_AW'(2) || hold_d !== exp_byte(16'hB002)) begin
         errors++;
         $display("FAIL stall_byte: got addr %h data %h, want 2 %h", hold_a, hold_d, exp_byte(16'hB002));
      end
      for (int k = 1; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (up_valid !== 1'b1 || up_addr !== hold_a || up_data !== hold_d) begin
            errors++;
            $display("FAIL stall_hold%0d: got valid %b addr %h data %h, want 1 %h %h",
                     k, up_valid, up_addr, up_data, hold_a, hold_d);
         end
      end
      @(posedge clk);
      #1;
      up_ready = 1'b1;
      wait_done(1'b0, ok);
      checks++;
      if (hs_q.size() - h0 != 4) begin
         errors++;
         $display("FAIL stall_count: got %0d bytes, want 4", hs_q.size() - h0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            logic [ADDR_W-1:0] a = 16'hB000 + ADDR_W'(i);
            checks++;
            if (hs_q[h0+i].a !== OUT_AW'(i) || hs_q[h0+i].d !== exp_byte(a)) begin
               errors++;
               $display("FAIL stall_byte%0d: got addr %h data %h, want addr %h data %h",
                        i, hs_q[h0+i].a, hs_q[h0+i].d, i, exp_byte(a));
            end
         end
      end
   endtask

   task automatic test_wrap();
      int h0 = hs_q.size();
      int r0 = rd_q.size();
      bit ok;
      logic [ADDR_W-1:0] exp_rd[3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
      pulse_start(16'hFFFE, 16'd3);
      wait_done(1'b1, ok);
      checks++;
      if (rd_q.size() - r0 != 3 || hs_q.size() - h0 != 3) begin
         errors++;
         $display("FAIL wrap_count: got %0d reads %0d bytes, want 3 3", rd_q.size() - r0, hs_q.size() - h0);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_q[r0+i] !== exp_rd[i] || hs_q[h0+i].a !== OUT_AW'(i) || hs_q[h0+i].d !== exp_byte(exp_rd[i])) begin
               errors++;
               $display("FAIL wrap_%0d: got rd %h addr %h data %h, want rd %h addr %h data %h",
                        i, rd_q[r0+i], hs_q[h0+i].a, hs_q[h0+i].d, exp_rd[i], i, exp_byte(exp_rd[i]));
            end
         end
      end
   endtask

   task automatic test_empty();
      int h0 = hs_q.size();
      int r0 = rd_q.size();
      int d0 = done_cnt;
      int b0 = busy_cnt;
      pulse_start(16'h5555, 16'd0);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL empty_cycle1: got done %b busy %b, want 0 0", done, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL empty_cycle2: got done %b busy %b, want 1 0", done, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL empty_cycle3: got done %b, want 0", done); end
      @(posedge clk);
      #1;
      checks++;
      if (rd_q.size() != r0 || hs_q.size() != h0 || busy_cnt != b0 || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL empty_activity: got reads %0d bytes %0d busy %0d done %0d, want 0 0 0 1",
                  rd_q.size() - r0, hs_q.size() - h0, busy_cnt - b0, done_cnt - d0);
      end
   endtask

   task automatic test_abort();
      int h0 = hs_q.size();
      int r0 = rd_q.size();
      int d0 = done_cnt;
      bit ok;
      up_ready = 1'b1;
      pulse_start(16'h1230, 16'd10);
      repeat (5) tick();
      abort = 1'b1;
      @(negedge clk);
      checks++;
      if (up_valid !== 1'b1 || up_addr !== OUT_AW'(1)) begin
         errors++;
         $display("FAIL abort_in_send: got valid %b addr %h, want 1 1", up_valid, up_addr);
      end
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || up_valid !== 1'b0 || mem_rd !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_next: got busy %b valid %b mem_rd %b done %b, want 0 0 0 0",
                  busy, up_valid, mem_rd, done);
      end
      @(posedge clk);
      #1;
      repeat (6) tick();
      checks++;
      if (hs_q.size() - h0 != 1 || done_cnt != d0 || rd_q.size() - r0 != 2) begin
         errors++;
         $display("FAIL abort_totals: got bytes %0d done %0d reads %0d, want 1 0 2",
                  hs_q.size() - h0, done_cnt - d0, rd_q.size() - r0);
      end else begin
         checks++;
         if (hs_q[h0].a !== '0 || hs_q[h0].d !== exp_byte(16'h1230)) begin
            errors++;
            $display("FAIL abort_byte0: got addr %h data %h, want 0 %h", hs_q[h0].a, hs_q[h0].d, exp_byte(16'h1230));
         end
      end
      h0 = hs_q.size();
      pulse_start(16'h4000, 16'd3);
      wait_done(1'b0, ok);
      checks++;
      if (hs_q.size() - h0 != 3) begin
         errors++;
         $display("FAIL abort_restart_count: got %0d bytes, want 3", hs_q.size() - h0);
      end else begin
         for (int i = 0; i < 3; i++) begin
            logic [ADDR_W-1:0] a = 16'h4000 + ADDR_W'(i);
            checks++;
            if (hs_q[h0+i].a !== OUT_AW'(i) || hs_q[h0+i].d !== exp_byte(a)) begin
               errors++;
               $display("FAIL abort_restart%0d: got addr %h data %h, want addr %h data %h",
                        i, hs_q[h0+i].a, hs_q[h0+i].d, i, exp_byte(a));
            end
         end
      end
   endtask

   task automatic test_start_while_busy();
      int h0 = hs_q.size();
      int d0 = done_cnt;
      bit ok;
      pulse_start(16'h2000, 16'd5);
      repeat (2) tick();
      pulse_start(16'h9000, 16'd2);
      wait_done(1'b1, ok);
      repeat (6) tick();
      checks++;
      if (hs_q.size() - h0 != 5 || done_cnt - d0 != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_start_count: got bytes %0d done %0d busy %b, want 5 1 0",
                  hs_q.size() - h0, done_cnt - d0, busy);
      end else begin
         for (int i = 0; i < 5; i++) begin
            logic [ADDR_W-1:0] a = 16'h2000 + ADDR_W'(i);
            checks++;
            if (hs_q[h0+i].a !== OUT_AW'(i) || hs_q[h0+i].d !== exp_byte(a)) begin
               errors++;
               $display("FAIL busy_start%0d: got addr %h data %h, want addr %h data %h",
                        i, hs_q[h0+i].a, hs_q[h0+i].d, i, exp_byte(a));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int h0;
      int d0 = done_cnt;
      bit ok;
      pulse_start(16'h3000, 16'd8);
      repeat (4) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done, cpu_hold, mem_rd, up_valid} !== 5'b0 || mem_addr !== '0 || up_data !== '0 || up_addr !== '0) begin
         errors++;
         $display("FAIL reset_mid: got ctrl %b mem_addr %h data %h addr %h, want all 0",
                  {busy, done, cpu_hold, mem_rd, up_valid}, mem_addr, up_data, up_addr);
      end
      @(posedge clk);
      #1;
      repeat (3) tick();
      checks++;
      if (done_cnt != d0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_idle: got done %0d busy %b, want 0 0", done_cnt - d0, busy);
      end
      h0 = hs_q.size();
      pulse_start(16'h3100, 16'd2);
      wait_done(1'b0, ok);
      checks++;
      if (hs_q.size() - h0 != 2) begin
         errors++;
         $display("FAIL reset_fresh_count: got %0d bytes, want 2", hs_q.size() - h0);
      end else begin
         for (int i = 0; i < 2; i++) begin
            logic [ADDR_W-1:0] a = 16'h3100 + ADDR_W'(i);
            checks++;
            if (hs_q[h0+i].a !== OUT_AW'(i) || hs_q[h0+i].d !== exp_byte(a)) begin
               errors++;
               $display("FAIL reset_fresh%0d: got addr %h data %h, want addr %h data %h",
                        i, hs_q[h0+i].a, hs_q[h0+i].d, i, exp_byte(a));
            end
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 16; n++) begin
         logic [ADDR_W-1:0] b = ADDR_W'($urandom);
         int                l = $urandom_range(0, 12);
         int                h0 = hs_q.size();
         int                r0 = rd_q.size();
         int                d0 = done_cnt;
         bit                ok;
         if ($urandom_range(0, 3) == 0) b = 16'hFFF8 + ADDR_W'($urandom_range(0, 7));
         pulse_start(b, ADDR_W'(l));
         wait_done(1'b1, ok);
         checks++;
         if (!ok || done_cnt - d0 != 1 || hs_q.size() - h0 != l || rd_q.size() - r0 != l) begin
            errors++;
            $display("FAIL rand%0d_count: got done %0d bytes %0d reads %0d, want 1 %0d %0d",
                     n, done_cnt - d0, hs_q.size() - h0, rd_q.size() - r0, l, l);
         end else begin
            for (int i = 0; i < l; i++) begin
               logic [ADDR_W-1:0] a = b + ADDR_W'(i);
               checks++;
               if (rd_q[r0+i] !== a || hs_q[h0+i].a !== OUT_AW'(i) || hs_q[h0+i].d !== exp_byte(a)) begin
                  errors++;
                  $display("FAIL rand%0d_byte%0d: got rd %h addr %h data %h, want rd %h addr %h data %h",
                           n, i, rd_q[r0+i], hs_q[h0+i].a, hs_q[h0+i].d, a, i, exp_byte(a));
               end
            end
         end
      end
      checks++;
      if (hold_err != 0) begin
         errors++;
         $display("FAIL cpu_hold: got %0d cycles differing from busy, want 0", hold_err);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_empty();
      test_abort();
      test_start_while_busy();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
